mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory (8-bit word address, combinational read, clocked write) between the instruction-fetch port and the data load/store port of the cpu5 core.
- Arbitrates requests: data has priority, with an anti-starvation override for fetch.
- Sequences each access through a fixed number of memory wait-state cycles and returns a registered response with a one-cycle ack.

Parameters:
- DW, `CPU5_XLEN (32): data width of all data buses.
- AW, 8: word address width.
- LATENCY, 1: cycles an access occupies memory; legal range 1..15.
- STARVE_MAX, 4: consecutive lost arbitrations after which fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  AW  fetch word address; stable while if_req is high.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DW  fetch read data; valid only while if_ack is high.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DW  read data (for a write: pre-write contents); valid only while d_ack is high.
- mem_we  out  1  memory write strobe.
- mem_a  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory combinational read data.
- grant  out  2  one-hot current owner {data, fetch}; 00 when idle or responding.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; if_ack, d_ack, mem_we=0; mem_a, mem_wd, rdata register, starve_cnt, wait counter=0; grant=00.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: samples if_req/d_req.
  - Neither high: stay in IDLE.
  - Winner is fetch if only if_req is high, or if both are high and starve_cnt==STARVE_MAX; otherwise data.
  - Latch the winner's address into mem_a and d_wdata into mem_wd (data winner only; mem_wd holds otherwise).
  - Set grant; load cnt=LATENCY-1; go to ACCESS.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when both requests are high and data wins.
  - Clears when fetch wins.
  - Unchanged otherwise.
- ACCESS: mem_a/mem_wd held stable; cnt decrements each cycle.
  - Final cycle (cnt==0): mem_we=1 only if the owner is data with d_we=1 (exactly one write pulse per write access); capture mem_rd into rdata on this edge.
  - Because the memory writes on the same edge, a write returns the old contents.
  - Then go to RESP; grant=00.
- RESP: owner's ack=1 for exactly one cycle; if_rdata and d_rdata both equal rdata; return to IDLE.
- Latency: request seen in IDLE at cycle T → ACCESS in cycles T+1..T+LATENCY → ack in cycle T+LATENCY+1.
- Throughput: one access per LATENCY+2 cycles.
- Requester rule: req and payload stay stable until the ack cycle. If req is still high in the cycle after ack, that is a new request, sampled in IDLE.
- Request dropped mid-access: access still completes and the ack still pulses. The requester must ignore it. No cancellation.
- Non-owner request arriving mid-access: waits; re-arbitrated in the next IDLE.
- Reset during ACCESS before the final cycle: no write occurs, no ack, FSM returns to IDLE.
- Reset during RESP: the ack drops immediately.
- if_ack and d_ack are never high in the same cycle; mem_we is never high outside ACCESS.

Test Plan:
- Single read: memory preloaded with word[0x10]=0xDEADBEEF, LATENCY=1; if_req with if_addr=0x10 in cycle 0 → grant=01 in cycle 1, if_ack=1 and if_rdata=0xDEADBEEF in cycle 2, if_ack=0 in cycle 3.
- Write then read: d_req, d_we=1, d_addr=0x20, d_wdata=0x12345678 (old value 0) → exactly one mem_we pulse; d_ack with d_rdata=0. A following read of 0x20 returns 0x12345678.
- Simultaneous requests: if_req and d_req both held continuously, STARVE_MAX=4 → ack order D,D,D,D,I,D,D,D,D,I; starve_cnt clears on each fetch win.
- Latency sweep: LATENCY=3, fetch read → ACCESS for cycles 1–3, ack in cycle 4. mem_a is stable across cycles 1–3; back-to-back reads ack every 5 cycles.
- Reset mid-write: LATENCY=4 write to 0x30; assert reset in cycle 2 → no mem_we pulse, no d_ack, grant=00. Word 0x30 is unchanged; the bench re-issues the write and it completes normally.
- Early req drop: fetch req dropped in cycle 1 → if_ack still pulses in cycle 2; FSM returns to IDLE, and the next data request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif
// ============================================================================
// mem_port_arbiter_if : fetch, data and memory buses of mem_port_arbiter
// Revision 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int DW = `CPU5_XLEN,
  parameter int AW = 8
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic [1:0]    grant;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    output if_ack, if_rdata, d_ack, d_rdata, mem_we, mem_a, mem_wd, grant
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_we, mem_a, mem_wd, grant
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif
// ============================================================================
// mem_port_arbiter : shares one single-ported memory between fetch and data
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int DW         = `CPU5_XLEN,
  parameter int AW         = 8,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [3:0]    starve_cnt, starve_nxt;
  logic          owner_d, owner_nxt;
  logic          wr, wr_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] wd_q, wd_nxt;
  logic [DW-1:0] rdata, rdata_nxt;
  logic          mem_we_q, mem_we_nxt;
  logic          if_ack_q, if_ack_nxt;
  logic          d_ack_q, d_ack_nxt;
  logic [1:0]    grant_q, grant_nxt;
  logic          fetch_wins;

  assign fetch_wins = bus.if_req && (!bus.d_req || starve_cnt == 4'(STARVE_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      owner_d    <= 1'b0;
      wr         <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      rdata      <= '0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      grant_q    <= 2'b00;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      starve_cnt <= starve_nxt;
      owner_d    <= owner_nxt;
      wr         <= wr_nxt;
      addr_q     <= addr_nxt;
      wd_q       <= wd_nxt;
      rdata      <= rdata_nxt;
      mem_we_q   <= mem_we_nxt;
      if_ack_q   <= if_ack_nxt;
      d_ack_q    <= d_ack_nxt;
      grant_q    <= grant_nxt;
    end
  end

  // Every output is a register, so the write strobe is raised one cycle ahead
  // so that it is high exactly during the final ACCESS cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    starve_nxt = starve_cnt;
    owner_nxt  = owner_d;
    wr_nxt     = wr;
    addr_nxt   = addr_q;
    wd_nxt     = wd_q;
    rdata_nxt  = rdata;
    mem_we_nxt = 1'b0;
    if_ack_nxt = 1'b0;
    d_ack_nxt  = 1'b0;
    grant_nxt  = 2'b00;
    case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          if (fetch_wins) begin
            owner_nxt  = 1'b0;
            wr_nxt     = 1'b0;
            addr_nxt   = bus.if_addr;
            starve_nxt = '0;
            grant_nxt  = 2'b01;
          end else begin
            owner_nxt  = 1'b1;
            wr_nxt     = bus.d_we;
            addr_nxt   = bus.d_addr;
            wd_nxt     = bus.d_wdata;
            grant_nxt  = 2'b10;
            if (bus.if_req) begin
              starve_nxt = starve_cnt + 4'd1;
            end
            mem_we_nxt = bus.d_we && (LATENCY == 1);
          end
          cnt_nxt   = 4'(LATENCY - 1);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        grant_nxt = grant_q;
        if (cnt == 4'd0) begin
          rdata_nxt  = bus.mem_rd;
          grant_nxt  = 2'b00;
          if_ack_nxt = !owner_d;
          d_ack_nxt  = owner_d;
          state_nxt  = RESP;
        end else begin
          cnt_nxt    = cnt - 4'd1;
          mem_we_nxt = owner_d && wr && (cnt == 4'd1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.if_ack   = if_ack_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.if_rdata = rdata;
  assign bus.d_rdata  = rdata;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_a    = addr_q;
  assign bus.mem_wd   = wd_q;
  assign bus.grant    = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mem_port_arbiter : directed and randomized checks of mem_port_arbiter
// Revision 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int N  = 3;
  localparam int SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_v     [N];
  logic          if_req_v  [N];
  logic [AW-1:0] if_addr_v [N];
  logic          d_req_v   [N];
  logic          d_we_v    [N];
  logic [AW-1:0] d_addr_v  [N];
  logic [DW-1:0] d_wdata_v [N];
  logic          if_ack_v  [N];
  logic [DW-1:0] if_rd_v   [N];
  logic          d_ack_v   [N];
  logic [DW-1:0] d_rd_v    [N];
  logic          mem_we_v  [N];
  logic [AW-1:0] mem_a_v   [N];
  logic [DW-1:0] mem_wd_v  [N];
  logic [1:0]    grant_v   [N];

  logic [DW-1:0] mem     [N][256];
  logic [DW-1:0] ref_mem [N][256];
  int            we_cnt  [N];
  logic          clr = 1'b1;
  logic          poke_en = 1'b0;
  int            poke_k = 0;
  logic [AW-1:0] poke_a = '0;
  logic [DW-1:0] poke_d = '0;
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();
    assign bus.if_req  = if_req_v[g];
    assign bus.if_addr = if_addr_v[g];
    assign bus.d_req   = d_req_v[g];
    assign bus.d_we    = d_we_v[g];
    assign bus.d_addr  = d_addr_v[g];
    assign bus.d_wdata = d_wdata_v[g];
    assign bus.mem_rd  = mem[g][bus.mem_a];
    assign if_ack_v[g] = bus.if_ack;
    assign if_rd_v[g]  = bus.if_rdata;
    assign d_ack_v[g]  = bus.d_ack;
    assign d_rd_v[g]   = bus.d_rdata;
    assign mem_we_v[g] = bus.mem_we;
    assign mem_a_v[g]  = bus.mem_a;
    assign mem_wd_v[g] = bus.mem_wd;
    assign grant_v[g]  = bus.grant;
    mem_port_arbiter #(
      .DW(DW), .AW(AW),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .STARVE_MAX(SM)
    ) dut (
      .clk(clk), .reset(rst_v[g]), .bus(bus.slave)
    );
  end

  // Memory behind each arbiter: combinational read, clocked write.
  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < N; k++)
        for (int a = 0; a < 256; a++) mem[k][a] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (mem_we_v[k]) begin
          mem[k][mem_a_v[k]] <= mem_wd_v[k];
          we_cnt[k] <= we_cnt[k] + 1;
        end
      end
      if (poke_en) mem[poke_k][poke_a] <= poke_d;
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_k = k; poke_a = a; poke_d = d; poke_en = 1'b1;
    ref_mem[k][a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic wait_ack(input int k, input bit dport, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = dport ? d_ack_v[k] : if_ack_v[k];
    end
    chk("ack_within_budget", got, 1'b1);
  endtask

  // Transaction-level model: the arbiter is free at cycle idle_at; a winner
  // chosen there acks LATENCY+1 cycles later and frees it one cycle after.
  task automatic run_random(input int k, input int ncyc);
    int lat, c, idle_at, s, ack_at, losses, nwr, we0;
    bit f_pend, d_pend, own_d;
    logic [AW-1:0] f_addr, dd_addr;
    logic [DW-1:0] dd_wdata, exp_rd;
    bit dd_we;
    lat = lat_of(k);
    c = 0; idle_at = 0; s = -100; ack_at = -1; losses = 0; nwr = 0;
    f_pend = 0; d_pend = 0; own_d = 0; exp_rd = '0;
    f_addr = '0; dd_addr = '0; dd_wdata = '0; dd_we = 0;
    rst_v[k] = 1'b1;
    @(negedge clk);
    rst_v[k] = 1'b0;
    we0 = we_cnt[k];
    while ((c < ncyc || f_pend || d_pend || c < idle_at) && c < ncyc + 100) begin
      chk("rnd_if_ack", if_ack_v[k], (c == ack_at) && !own_d);
      chk("rnd_d_ack", d_ack_v[k], (c == ack_at) && own_d);
      if (c == ack_at) begin
        chk(own_d ? "rnd_d_rdata" : "rnd_if_rdata", own_d ? d_rd_v[k] : if_rd_v[k], exp_rd);
        if (own_d) d_pend = 0; else f_pend = 0;
      end
      chk("rnd_grant", grant_v[k], (c > s && c <= s + lat) ? (own_d ? 2'b10 : 2'b01) : 2'b00);
      if (c < ncyc && !f_pend && ($urandom % 3 == 0)) begin
        f_pend = 1; f_addr = 8'h80 + 8'($urandom % 8);
      end
      if (c < ncyc && !d_pend && ($urandom % 3 == 0)) begin
        d_pend = 1; dd_addr = 8'h80 + 8'($urandom % 8);
        dd_we = 1'($urandom % 2); dd_wdata = $urandom;
      end
      if_req_v[k] = f_pend; if_addr_v[k] = f_addr;
      d_req_v[k] = d_pend; d_we_v[k] = dd_we; d_addr_v[k] = dd_addr; d_wdata_v[k] = dd_wdata;
      if (c == idle_at) begin
        if (f_pend || d_pend) begin
          own_d = d_pend && !(f_pend && losses == SM);
          if (own_d && f_pend) losses = losses + 1;
          if (!own_d) losses = 0;
          s = c; ack_at = c + lat + 1; idle_at = c + lat + 2;
          exp_rd = ref_mem[k][own_d ? dd_addr : f_addr];
          if (own_d && dd_we) begin
            ref_mem[k][dd_addr] = dd_wdata;
            nwr++;
          end
        end else begin
          idle_at = c + 1;
        end
      end
      @(negedge clk);
      c++;
    end
    chk("rnd_write_pulses", we_cnt[k] - we0, nwr);
    for (int a = 8'h80; a < 8'h88; a++) chk("rnd_mem_word", mem[k][a], ref_mem[k][a]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int w, gap;
    string order;
    for (int k = 0; k < N; k++) begin
      rst_v[k] = 1'b1; if_req_v[k] = 0; if_addr_v[k] = '0; d_req_v[k] = 0;
      d_we_v[k] = 0; d_addr_v[k] = '0; d_wdata_v[k] = '0;
      for (int a = 0; a < 256; a++) ref_mem[k][a] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("rst_grant", grant_v[k], 2'b00);
      chk("rst_acks", {if_ack_v[k], d_ack_v[k], mem_we_v[k]}, 3'b000);
      chk("rst_mem_a", mem_a_v[k], 8'h00);
      chk("rst_mem_wd", mem_wd_v[k], 32'h0);
      rst_v[k] = 1'b0;
    end

    // Single fetch read, LATENCY=1
    poke(0, 8'h10, 32'hDEADBEEF);
    if_req_v[0] = 1; if_addr_v[0] = 8'h10;
    @(negedge clk);
    chk("rd_grant_c1", grant_v[0], 2'b01);
    chk("rd_noack_c1", if_ack_v[0], 1'b0);
    @(negedge clk);
    chk("rd_ack_c2", if_ack_v[0], 1'b1);
    chk("rd_data_c2", if_rd_v[0], 32'hDEADBEEF);
    if_req_v[0] = 0;
    @(negedge clk);
    chk("rd_ack_c3", if_ack_v[0], 1'b0);
    chk("rd_grant_c3", grant_v[0], 2'b00);

    // Write then read back
    w = we_cnt[0];
    d_req_v[0] = 1; d_we_v[0] = 1; d_addr_v[0] = 8'h20; d_wdata_v[0] = 32'h12345678;
    wait_ack(0, 1, 10, got);
    chk("wr_old_data", d_rd_v[0], 32'h0);
    chk("wr_no_if_ack", if_ack_v[0], 1'b0);
    d_req_v[0] = 0;
    @(negedge clk);
    chk("wr_pulses", we_cnt[0] - w, 1);
    chk("wr_mem", mem[0][8'h20], 32'h12345678);
    d_req_v[0] = 1; d_we_v[0] = 0;
    wait_ack(0, 1, 10, got);
    chk("wr_readback", d_rd_v[0], 32'h12345678);
    d_req_v[0] = 0;
    @(negedge clk);

    // Both requests held: fetch wins once after every SM data wins
    if_req_v[0] = 1; if_addr_v[0] = 8'h10;
    d_req_v[0] = 1; d_we_v[0] = 0; d_addr_v[0] = 8'h20;
    order = "";
    for (int n = 0; n < 10; n++) begin
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        chk("both_acks_exclusive", if_ack_v[0] && d_ack_v[0], 1'b0);
        got = if_ack_v[0] || d_ack_v[0];
      end
      chk("starve_ack_seen", got, 1'b1);
      chk("starve_order", d_ack_v[0], (n % (SM + 1)) != SM);
      order = {order, d_ack_v[0] ? "D" : "I"};
    end
    if_req_v[0] = 0; d_req_v[0] = 0;
    @(negedge clk);

    // LATENCY=3: grant and address held over three ACCESS cycles, ack every 5
    poke(1, 8'h05, 32'hCAFEF00D);
    if_req_v[1] = 1; if_addr_v[1] = 8'h05;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("lat_grant", grant_v[1], 2'b01);
      chk("lat_mem_a", mem_a_v[1], 8'h05);
      chk("lat_noack", if_ack_v[1], 1'b0);
    end
    @(negedge clk);
    chk("lat_ack_c4", if_ack_v[1], 1'b1);
    chk("lat_data_c4", if_rd_v[1], 32'hCAFEF00D);
    for (int r = 0; r < 2; r++) begin
      gap = 0; got = 0;
      while (!got && gap < 12) begin
        @(negedge clk);
        gap++;
        got = if_ack_v[1];
      end
      chk("lat_ack_spacing", gap, 5);
    end
    if_req_v[1] = 0;
    @(negedge clk);

    // LATENCY=4 write aborted by reset in cycle 2, then re-issued
    poke(2, 8'h30, 32'hA5A5A5A5);
    w = we_cnt[2];
    d_req_v[2] = 1; d_we_v[2] = 1; d_addr_v[2] = 8'h30; d_wdata_v[2] = 32'h11112222;
    @(negedge clk);
    chk("rstw_grant_c1", grant_v[2], 2'b10);
    @(negedge clk);
    rst_v[2] = 1; d_req_v[2] = 0;
    #1;
    chk("rstw_grant_async", grant_v[2], 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw_quiet", {d_ack_v[2], mem_we_v[2]}, 2'b00);
    end
    chk("rstw_no_pulse", we_cnt[2] - w, 0);
    chk("rstw_mem_kept", mem[2][8'h30], 32'hA5A5A5A5);
    rst_v[2] = 0;
    @(negedge clk);
    d_req_v[2] = 1;
    wait_ack(2, 1, 12, got);
    chk("rstw_old_data", d_rd_v[2], 32'hA5A5A5A5);
    d_req_v[2] = 0;
    @(negedge clk);
    chk("rstw_mem_new", mem[2][8'h30], 32'h11112222);
    chk("rstw_one_pulse", we_cnt[2] - w, 1);

    // Fetch request dropped mid-access still completes
    if_req_v[0] = 1; if_addr_v[0] = 8'h10;
    @(negedge clk);
    if_req_v[0] = 0;
    @(negedge clk);
    chk("drop_ack_c2", if_ack_v[0], 1'b1);
    chk("drop_data_c2", if_rd_v[0], 32'hDEADBEEF);
    @(negedge clk);
    chk("drop_idle_c3", {grant_v[0], if_ack_v[0]}, 3'b000);
    d_req_v[0] = 1; d_we_v[0] = 0; d_addr_v[0] = 8'h20;
    @(negedge clk);
    chk("drop_next_grant", grant_v[0], 2'b10);
    wait_ack(0, 1, 10, got);
    chk("drop_next_data", d_rd_v[0], 32'h12345678);
    d_req_v[0] = 0;
    @(negedge clk);

    run_random(0, 400);
    run_random(1, 400);
    run_random(2, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
